// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types for the fetch/data unified-memory arbiter: FSM states, grant
// identities, latched operation codes and the wait-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

    // A data request with d_wr set is a write even if d_rd is also high.
    function automatic op_t decode_op(input grant_t g, input logic d_wr);
        op_t op;
        op = OP_FETCH;
        if (g == DATA) begin
            op = d_wr ? OP_WRITE : OP_READ;
        end
        return op;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's
// view, master is the view of the core plus memory model driving it.
interface shared_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_adr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;

    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_adr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_read;
    logic          m_write;

    modport slave (
        input  if_req, if_adr, d_rd, d_wr, d_adr, d_wdata, m_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
               m_adr, m_wdata, m_read, m_write
    );

    modport master (
        output if_req, if_adr, d_rd, d_wr, d_adr, d_wdata, m_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
               m_adr, m_wdata, m_read, m_write
    );
endinterface

// File: rtl/shared_mem_arbiter_arb_rr2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the port opposite the last completed grant.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  grant_t     upd_grant_i,
    output grant_t     grant_o
);

    grant_t last_grant_q;

    always_comb begin
        grant_o = FETCH;
        if (req_i == 2'b11) begin
            grant_o = (last_grant_q == FETCH) ? DATA : FETCH;
        end else if (req_i[1]) begin
            grant_o = DATA;
        end
    end

    // Starting at FETCH lets data win the very first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= FETCH;
        end else if (upd_i) begin
            last_grant_q <= upd_grant_i;
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Sequences one single-port memory between instruction fetch and the data
// port: grant, hold the access for LATENCY cycles, then pulse ready once.
module shared_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_mem_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [31:0]          stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           state_q;
    grant_t           grant_q;
    grant_t           pick;
    op_t              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    adr_q;
    logic [DW-1:0]    wdata_q;
    logic [DW-1:0]    if_rdata_q;
    logic [DW-1:0]    d_rdata_q;
    logic             m_read_q;
    logic             m_write_q;
    logic             if_ready_q;
    logic             d_ready_q;
    logic [31:0]      stall_q;
    logic [31:0]      stall_d;
    logic             d_req;
    logic [1:0]       req;
    logic             pending;

    assign d_req = bus.d_rd | bus.d_wr;
    assign req   = {d_req, bus.if_req};

    arb_rr2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .upd_i       (state_q == RESP),
        .upd_grant_i (grant_q),
        .grant_o     (pick)
    );

    // A ready pulse ends that port's stall in the same cycle, and a cycle
    // with both ports waiting counts once.
    assign pending = (bus.if_req & ~if_ready_q) | (d_req & ~d_ready_q);
    assign stall_d = (pending && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= FETCH;
            op_q       <= OP_FETCH;
            cnt_q      <= '0;
            adr_q      <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            m_read_q   <= 1'b0;
            m_write_q  <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            stall_q    <= stall_d;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        grant_q   <= pick;
                        op_q      <= decode_op(pick, bus.d_wr);
                        adr_q     <= (pick == DATA) ? bus.d_adr : bus.if_adr;
                        wdata_q   <= (pick == DATA) ? bus.d_wdata : '0;
                        m_read_q  <= !((pick == DATA) && bus.d_wr);
                        // With a one-cycle access the first BUSY cycle is also the last.
                        m_write_q <= (pick == DATA) && bus.d_wr && (LATENCY == 1);
                        cnt_q     <= CNT_LOAD;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        if (grant_q == DATA) begin
                            d_rdata_q <= bus.m_rdata;
                            d_ready_q <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.m_rdata;
                            if_ready_q <= 1'b1;
                        end
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q     <= cnt_q - 1'b1;
                        m_write_q <= (op_q == OP_WRITE) && (cnt_q == CNT_W'(1));
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_adr    = adr_q;
    assign bus.m_wdata  = wdata_q;
    assign bus.m_read   = m_read_q;
    assign bus.m_write  = m_write_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.if_ready = if_ready_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_ready  = d_ready_q;
    assign busy         = (state_q != IDLE);
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Four arbiter builds (LATENCY 1, 2, 3, 15) each with its own memory model;
// the LATENCY=2 build is checked through a completion scoreboard.
module tb_shared_mem_arbiter;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic        rst_a     [NI];
    logic        mem_init;
    logic        cnt_clr;
    logic [7:0]  probe_idx;
    logic        if_req_a  [NI];
    logic [31:0] if_adr_a  [NI];
    logic        d_rd_a    [NI];
    logic        d_wr_a    [NI];
    logic [31:0] d_adr_a   [NI];
    logic [31:0] d_wdata_a [NI];
    logic [31:0] if_rdata_a[NI];
    logic [31:0] d_rdata_a [NI];
    logic [31:0] m_adr_a   [NI];
    logic [31:0] m_wdata_a [NI];
    logic [31:0] stall_a   [NI];
    logic [31:0] probe_a   [NI];
    logic        if_ready_a[NI];
    logic        d_ready_a [NI];
    logic        m_read_a  [NI];
    logic        m_write_a [NI];
    logic        busy_a    [NI];
    logic        glitch_a  [NI];
    int          wcnt_a    [NI];
    int          rcnt_a    [NI];

    function automatic logic [31:0] pat(input int i);
        return (i == 1) ? 32'h2008_0005 : (32'hA500_0000 | 32'(i));
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 15;

        shared_mem_arbiter_if #(.AW(32), .DW(32)) bus ();
        logic [31:0] mem [0:255];
        logic        busy_w;
        logic [31:0] stall_w;
        int          wcnt;
        int          rcnt;
        logic        glitch;
        logic        prev_busy;
        logic [31:0] prev_adr;

        shared_mem_arbiter #(.LATENCY(LAT), .AW(32), .DW(32)) dut (
            .clk       (clk),
            .rst       (rst_a[gi]),
            .bus       (bus),
            .busy      (busy_w),
            .stall_cnt (stall_w)
        );

        assign bus.if_req  = if_req_a[gi];
        assign bus.if_adr  = if_adr_a[gi];
        assign bus.d_rd    = d_rd_a[gi];
        assign bus.d_wr    = d_wr_a[gi];
        assign bus.d_adr   = d_adr_a[gi];
        assign bus.d_wdata = d_wdata_a[gi];
        assign bus.m_rdata = mem[bus.m_adr[9:2]];

        assign if_rdata_a[gi] = bus.if_rdata;
        assign if_ready_a[gi] = bus.if_ready;
        assign d_rdata_a[gi]  = bus.d_rdata;
        assign d_ready_a[gi]  = bus.d_ready;
        assign m_adr_a[gi]    = bus.m_adr;
        assign m_wdata_a[gi]  = bus.m_wdata;
        assign m_read_a[gi]   = bus.m_read;
        assign m_write_a[gi]  = bus.m_write;
        assign busy_a[gi]     = busy_w;
        assign stall_a[gi]    = stall_w;
        assign probe_a[gi]    = mem[probe_idx];
        assign wcnt_a[gi]     = wcnt;
        assign rcnt_a[gi]     = rcnt;
        assign glitch_a[gi]   = glitch;

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            end else if (bus.m_write) begin
                mem[bus.m_adr[9:2]] <= bus.m_wdata;
            end
            if (cnt_clr) begin
                wcnt   <= 0;
                rcnt   <= 0;
                glitch <= 1'b0;
            end else begin
                if (bus.m_write) wcnt <= wcnt + 1;
                if (bus.if_ready || bus.d_ready) rcnt <= rcnt + 1;
                if (busy_w && prev_busy && (bus.m_adr !== prev_adr)) glitch <= 1'b1;
            end
            prev_busy <= busy_w;
            prev_adr  <= bus.m_adr;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard for the LATENCY=2 build: port (0 fetch, 1 data), data, due cycle.
    typedef struct {
        bit          port;
        bit          chk;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sbq[$];

    always @(negedge clk) begin
        exp_t        e;
        bit          got_port;
        logic [31:0] got;
        if (!rst_a[1] && (if_ready_a[1] || d_ready_a[1])) begin
            got_port = d_ready_a[1];
            got      = got_port ? d_rdata_a[1] : if_rdata_a[1];
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: ready on port %0d with nothing pending (cycle %0d)", got_port, cyc);
            end else begin
                e = sbq.pop_front();
                $display("[TB] txn port=%s data=%h cycle=%0d", got_port ? "DATA " : "FETCH", got, cyc);
                check("sb_port", 32'(got_port), 32'(e.port));
                check("sb_cycle", cyc, e.due);
                if (e.chk) check("sb_rdata", got, e.data);
            end
        end
    end

    task automatic run_txn(input int k, input bit fetch, input bit rd, input bit wr,
                           input logic [31:0] adr, input logic [31:0] wd,
                           input bit chk, input logic [31:0] exp,
                           output int lat, output logic [31:0] rdata);
        int t0;
        bit done;
        done  = 1'b0;
        lat   = -1;
        rdata = '0;
        @(negedge clk);
        if (fetch) begin
            if_req_a[k] = 1'b1;
            if_adr_a[k] = adr;
        end else begin
            d_rd_a[k]    = rd;
            d_wr_a[k]    = wr;
            d_adr_a[k]   = adr;
            d_wdata_a[k] = wd;
        end
        t0 = cyc;
        if (k == 1) sbq.push_back('{port: !fetch, chk: chk, data: exp, due: t0 + 3});
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if ((fetch && if_ready_a[k]) || (!fetch && d_ready_a[k])) begin
                done  = 1'b1;
                lat   = cyc - t0;
                rdata = fetch ? if_rdata_a[k] : d_rdata_a[k];
            end
        end
        if_req_a[k] = 1'b0;
        d_rd_a[k]   = 1'b0;
        d_wr_a[k]   = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL txn_timeout: inst %0d adr %h no ready within 40 cycles", k, adr);
        end
    endtask

    typedef struct {
        bit          fetch;
        bit          rd;
        bit          wr;
        logic [31:0] adr;
        logic [31:0] wd;
        bit          chk;
        logic [31:0] exp;
        int          writes;
    } vec_t;

    initial begin
        vec_t        vt[8];
        int          lat;
        int          c;
        int          seen;
        bit          done;
        logic [31:0] rd;
        logic [31:0] s0;

        for (int k = 0; k < NI; k++) begin
            rst_a[k]     = 1'b1;
            if_req_a[k]  = 1'b0;
            if_adr_a[k]  = '0;
            d_rd_a[k]    = 1'b0;
            d_wr_a[k]    = 1'b0;
            d_adr_a[k]   = '0;
            d_wdata_a[k] = '0;
        end
        mem_init  = 1'b1;
        cnt_clr   = 1'b1;
        probe_idx = '0;

        //           fetch rd wr  adr            wdata          chk exp            writes
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h2008_0005, 0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_03E8, 32'hDEAD_BEEF, 1'b0, 32'h0,         1};
        vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_03E8, 32'h0,         1'b1, 32'hDEAD_BEEF, 0};
        vt[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'hA500_0002, 0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_000C, 32'hCAFE_F00D, 1'b0, 32'h0,         1};
        vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0,         1'b1, 32'hCAFE_F00D, 0};
        vt[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0,         1'b1, 32'hCAFE_F00D, 0};
        vt[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h2008_0005, 0};

        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        cnt_clr  = 1'b0;

        check("rst_busy",     32'(busy_a[1]),     32'h0);
        check("rst_if_ready", 32'(if_ready_a[1]), 32'h0);
        check("rst_d_ready",  32'(d_ready_a[1]),  32'h0);
        check("rst_m_rw",     {30'h0, m_read_a[1], m_write_a[1]}, 32'h0);
        check("rst_m_adr",    m_adr_a[1],         32'h0);
        check("rst_m_wdata",  m_wdata_a[1],       32'h0);
        check("rst_rdata",    if_rdata_a[1] | d_rdata_a[1], 32'h0);
        check("rst_stall",    stall_a[1],         32'h0);

        for (int k = 0; k < NI; k++) rst_a[k] = 1'b0;
        @(negedge clk);

        // Table of single transactions on the LATENCY=2 build.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) cnt_clr = 1'b1;
            @(negedge clk) cnt_clr = 1'b0;
            run_txn(1, vt[i].fetch, vt[i].rd, vt[i].wr, vt[i].adr, vt[i].wd,
                    vt[i].chk, vt[i].exp, lat, rd);
            check($sformatf("vec%0d_writes", i), wcnt_a[1], vt[i].writes);
            @(negedge clk);
            check($sformatf("vec%0d_readies", i), rcnt_a[1], 1);
            check($sformatf("vec%0d_adr_stable", i), 32'(glitch_a[1]), 32'h0);
        end
        probe_idx = 8'd250;
        #1;
        check("mem_3e8", probe_a[1], 32'hDEAD_BEEF);
        check("if_rdata_hold", if_rdata_a[1], 32'hCAFE_F00D);

        // Overlapping fetch and data waits: stall cycles counted as a union.
        @(negedge clk);
        s0 = stall_a[1];
        c  = cyc;
        if_req_a[1] = 1'b1;
        if_adr_a[1] = 32'h10;
        sbq.push_back('{port: 1'b0, chk: 1'b1, data: 32'hA500_0004, due: c + 3});
        repeat (2) @(negedge clk);
        d_rd_a[1]  = 1'b1;
        d_adr_a[1] = 32'h14;
        sbq.push_back('{port: 1'b1, chk: 1'b1, data: 32'hA500_0005, due: c + 7});
        done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (if_ready_a[1]) if_req_a[1] = 1'b0;
            if (d_ready_a[1]) begin
                d_rd_a[1] = 1'b0;
                done      = 1'b1;
            end
        end
        if_req_a[1] = 1'b0;
        d_rd_a[1]   = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL stall_timeout: overlap sequence did not complete");
        end
        repeat (2) @(negedge clk);
        check("stall_union", stall_a[1] - s0, 32'd7);

        // Both ports held from reset: data first, then strict alternation.
        rst_a[1]    = 1'b1;
        if_req_a[1] = 1'b1;
        if_adr_a[1] = 32'h10;
        d_rd_a[1]   = 1'b1;
        d_adr_a[1]  = 32'h20;
        repeat (2) @(negedge clk);
        check("rr_rst_stall", stall_a[1], 32'h0);
        check("rr_rst_busy", 32'(busy_a[1]), 32'h0);
        rst_a[1] = 1'b0;
        c = cyc;
        for (int j = 0; j < 4; j++) begin
            sbq.push_back('{port: (j % 2 == 0), chk: 1'b1,
                            data: (j % 2 == 0) ? 32'hA500_0008 : 32'hA500_0004,
                            due: c + 3 + 4 * j});
        end
        seen = 0;
        for (int n = 0; n < 40 && seen < 4; n++) begin
            @(negedge clk);
            if (if_ready_a[1] || d_ready_a[1]) seen++;
        end
        if_req_a[1] = 1'b0;
        d_rd_a[1]   = 1'b0;
        check("rr_completions", seen, 4);
        repeat (3) @(negedge clk);

        // Extreme latencies: a single read on the LATENCY=1 and LATENCY=15 builds.
        @(negedge clk) cnt_clr = 1'b1;
        @(negedge clk) cnt_clr = 1'b0;
        run_txn(0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, lat, rd);
        check("lat1_cycles", lat, 2);
        check("lat1_rdata", rd, 32'h2008_0005);
        check("lat1_adr_stable", 32'(glitch_a[0]), 32'h0);
        run_txn(3, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, lat, rd);
        check("lat15_cycles", lat, 16);
        check("lat15_rdata", rd, 32'h2008_0005);
        check("lat15_adr_stable", 32'(glitch_a[3]), 32'h0);

        // Reset in the middle of a LATENCY=3 write, with cnt at 1.
        @(negedge clk) cnt_clr = 1'b1;
        @(negedge clk) cnt_clr = 1'b0;
        d_wr_a[2]    = 1'b1;
        d_adr_a[2]   = 32'h40;
        d_wdata_a[2] = 32'h1234_5678;
        repeat (2) @(negedge clk);
        check("abort_inflight", 32'(busy_a[2]), 32'h1);
        rst_a[2] = 1'b1;
        #1;
        check("abort_m_write", 32'(m_write_a[2]), 32'h0);
        check("abort_busy", 32'(busy_a[2]), 32'h0);
        check("abort_m_adr", m_adr_a[2], 32'h0);
        check("abort_m_wdata", m_wdata_a[2], 32'h0);
        check("abort_stall", stall_a[2], 32'h0);
        d_wr_a[2] = 1'b0;
        repeat (3) @(negedge clk);
        rst_a[2] = 1'b0;
        repeat (3) @(negedge clk);
        probe_idx = 8'd16;
        #1;
        check("abort_mem", probe_a[2], 32'hA500_0010);
        check("abort_writes", wcnt_a[2], 0);
        check("abort_readies", rcnt_a[2], 0);
        check("abort_ready_now", 32'(d_ready_a[2]), 32'h0);

        check("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
